// File: rtl/hash_request_scheduler.sv
// Request front-end for the hash table controller: queues read/write/delete
// requests and issues them one at a time, first driving the table read
// addresses and then, after the memory read latency, presenting the request
// to the controller for a single cycle.
module hash_request_scheduler #(
  parameter int KEY_WIDTH           = 2,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 2,
  parameter int MEM_READ_LATENCY    = 1,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            clk_en,
  input  logic                                            req_valid_i,
  output logic                                            req_ready_o,
  input  logic [KEY_WIDTH-1:0]                            req_key_i,
  input  logic [DATA_WIDTH-1:0]                           req_data_i,
  input  logic [1:0]                                      req_op_i,
  input  logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] req_hash_adr_i,
  output logic                                            mem_rd_en_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] mem_rd_adr_o,
  output logic [KEY_WIDTH-1:0]                            key_o,
  output logic [DATA_WIDTH-1:0]                           data_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] hash_adr_o,
  output logic [1:0]                                      op_o,
  output logic                                            busy_o
);

  localparam int AW   = HASH_TABLE_MAX_SIZE * NUMBER_OF_TABLES;
  localparam int EW   = 2 + KEY_WIDTH + DATA_WIDTH + AW;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int LW   = $clog2(MEM_READ_LATENCY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;

  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  logic [1:0]            state;
  logic [LW-1:0]         cnt;
  logic [1:0]            op_l;
  logic [KEY_WIDTH-1:0]  key_l;
  logic [DATA_WIDTH-1:0] data_l;
  logic [AW-1:0]         adr_l;
  logic [KEY_WIDTH-1:0]  key_h;
  logic [DATA_WIDTH-1:0] data_h;
  logic [AW-1:0]         adr_h;

  // FIFO status, handshake and issue strobes
  always_comb begin
    full        = (count == CNTW'(FIFO_DEPTH));
    empty       = (count == '0);
    req_ready_o = !full && clk_en && !reset;
    push        = req_valid_i && req_ready_o && (req_op_i != 2'b00);
    pop         = clk_en && !reset && !empty && ((state == IDLE) || (state == EXEC));
    head        = fifo_mem[rd_ptr];
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_op_i, req_key_i, req_data_i, req_hash_adr_i};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue sequencer: load head, wait out the read latency, present for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_l   <= '0;
      key_l  <= '0;
      data_l <= '0;
      adr_l  <= '0;
      key_h  <= '0;
      data_h <= '0;
      adr_h  <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (pop) begin
            {op_l, key_l, data_l, adr_l} <= head;
            cnt   <= LW'(MEM_READ_LATENCY);
            state <= READ;
          end
        end
        READ: begin
          cnt <= cnt - LW'(1);
          if (cnt == LW'(1)) state <= EXEC;
        end
        EXEC: begin
          key_h  <= key_l;
          data_h <= data_l;
          adr_h  <= adr_l;
          if (pop) begin
            {op_l, key_l, data_l, adr_l} <= head;
            cnt   <= LW'(MEM_READ_LATENCY);
            state <= READ;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Controller-facing outputs; strobes suppressed while frozen or in reset.
  // key/data/addr show the live latch in EXEC and the last issued values otherwise,
  // so a back-to-back pop does not disturb them before the next issue.
  always_comb begin
    op_o         = (state == EXEC && clk_en && !reset) ? op_l : 2'b00;
    mem_rd_en_o  = (state == READ) && (cnt == LW'(MEM_READ_LATENCY)) && clk_en && !reset;
    mem_rd_adr_o = adr_l;
    key_o        = (state == EXEC) ? key_l  : key_h;
    data_o       = (state == EXEC) ? data_l : data_h;
    hash_adr_o   = (state == EXEC) ? adr_l  : adr_h;
    busy_o       = !reset && (!empty || (state != IDLE));
  end

endmodule

// File: tb/tb_hash_request_scheduler.sv
// Bench for hash_request_scheduler: two instances (read latency 1 and 3),
// directed scenarios with random request contents, and an in-order scoreboard
// of accepted requests that every issued operation is checked against.
module tb_hash_request_scheduler;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  key;
    logic [31:0] data;
    logic [5:0]  adr;
  } req_t;

  logic clk, reset, clk_en;

  logic        v1, rdy1, rden1, busy1;
  logic [1:0]  op1i, key1i, key1o, op1o;
  logic [31:0] data1i, data1o;
  logic [5:0]  adr1i, rdadr1, hash1o;

  logic        v3, rdy3, rden3, busy3;
  logic [1:0]  op3i, key3i, key3o, op3o;
  logic [31:0] data3i, data3o;
  logic [5:0]  adr3i, rdadr3, hash3o;

  hash_request_scheduler #(.MEM_READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_key_i(key1i), .req_data_i(data1i),
    .req_op_i(op1i), .req_hash_adr_i(adr1i), .mem_rd_en_o(rden1), .mem_rd_adr_o(rdadr1),
    .key_o(key1o), .data_o(data1o), .hash_adr_o(hash1o), .op_o(op1o), .busy_o(busy1));

  hash_request_scheduler #(.MEM_READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_key_i(key3i), .req_data_i(data3i),
    .req_op_i(op3i), .req_hash_adr_i(adr3i), .mem_rd_en_o(rden3), .mem_rd_adr_o(rdadr3),
    .key_o(key3o), .data_o(data3o), .hash_adr_o(hash3o), .op_o(op3o), .busy_o(busy3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  req_t q1[$];
  req_t q3[$];
  int   opcyc1[$];
  int   opcyc3[$];
  int   rd1_n = 0, op1_n = 0, rd1_cyc = -1, op1_cyc = -1;
  int   rd3_n = 0, op3_n = 0, rd3_cyc = -1, op3_cyc = -1, acc3_n = 0;
  logic chk_rdy3 = 1'b0;
  logic saw_full3 = 1'b0;

  logic s_rdy1, s_rd1, s_busy1, s_acc1, s_rdy3, s_rd3, s_busy3, s_acc3;
  logic [1:0] s_op1, s_op3;
  logic [5:0] s_adr3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    req_t r;
    s_rdy1 = rdy1; s_rd1 = rden1; s_busy1 = busy1; s_op1 = op1o;
    s_acc1 = v1 && rdy1;
    s_rdy3 = rdy3; s_rd3 = rden3; s_busy3 = busy3; s_op3 = op3o; s_adr3 = rdadr3;
    s_acc3 = v3 && rdy3;
    // latency-1 instance
    if (rden1) begin
      rd1_n++; rd1_cyc = cyc;
      if (q1.size() == 0) chk("rd1_spurious", 1'b1, 1'b0);
      else chk("rd1_adr", rdadr1, q1[0].adr);
    end
    if (op1o != 2'b00) begin
      if (q1.size() == 0) chk("op1_spurious", op1o, 2'b00);
      else begin
        r = q1.pop_front();
        chk("op1_op", op1o, r.op);
        chk("op1_key", key1o, r.key);
        chk("op1_data", data1o, r.data);
        chk("op1_adr", hash1o, r.adr);
      end
      op1_n++; op1_cyc = cyc; opcyc1.push_back(cyc);
    end
    if (s_acc1 && op1i != 2'b00) q1.push_back('{op1i, key1i, data1i, adr1i});
    // latency-3 instance
    if (rden3) begin
      rd3_n++; rd3_cyc = cyc;
      if (q3.size() == 0) chk("rd3_spurious", 1'b1, 1'b0);
      else chk("rd3_adr", rdadr3, q3[0].adr);
    end
    if (op3o != 2'b00) begin
      if (q3.size() == 0) chk("op3_spurious", op3o, 2'b00);
      else begin
        r = q3.pop_front();
        chk("op3_op", op3o, r.op);
        chk("op3_key", key3o, r.key);
        chk("op3_data", data3o, r.data);
        chk("op3_adr", hash3o, r.adr);
        chk("op3_rdadr_held", rdadr3, r.adr);
      end
      op3_n++; op3_cyc = cyc; opcyc3.push_back(cyc);
    end
    // occupancy = accepted minus popped; each pop shows up as a read strobe next cycle
    if (chk_rdy3) begin
      chk("rdy3_model", rdy3, ((acc3_n - rd3_n) < 4) ? 1'b1 : 1'b0);
      if (v3 && !rdy3) saw_full3 = 1'b1;
    end
    if (s_acc3 && op3i != 2'b00) begin
      q3.push_back('{op3i, key3i, data3i, adr3i});
      acc3_n++;
    end
    if (reset) begin
      q1.delete();
      q3.delete();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((s_busy1 || s_busy3 || q1.size() != 0 || q3.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    chk("idle_timeout", (k < 200) ? 1'b1 : 1'b0, 1'b1);
  endtask

  task automatic rand1();
    op1i = 2'($urandom_range(1, 3)); key1i = 2'($urandom);
    data1i = $urandom; adr1i = 6'($urandom);
  endtask

  task automatic rand3();
    op3i = 2'($urandom_range(1, 3)); key3i = 2'($urandom);
    data3i = $urandom; adr3i = 6'($urandom);
  endtask

  initial begin
    int t, k, n_rd, n_op;
    reset = 1'b1; clk_en = 1'b1;
    v1 = 1'b0; op1i = '0; key1i = '0; data1i = '0; adr1i = '0;
    v3 = 1'b0; op3i = '0; key3i = '0; data3i = '0; adr3i = '0;
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_op", s_op1, 2'b00);
    chk("rst_rd_en", s_rd1, 1'b0);
    chk("rst_busy", s_busy1, 1'b0);
    chk("rst_ready", s_rdy1, 1'b0);
    chk("rst_key", key1o, 2'b00);
    chk("rst_data", data1o, 32'h0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", s_rdy1, 1'b1);

    // single write, latency 1
    op1i = 2'b10; key1i = 2'b01; data1i = 32'hDEADBEEF; adr1i = {2'd2, 2'd1, 2'd0};
    v1 = 1'b1; t = cyc; tick(); v1 = 1'b0;
    wait_idle();
    chk("t1_rd_cycle", rd1_cyc, t + 2);
    chk("t1_op_cycle", op1_cyc, t + 3);
    chk("t1_op_count", op1_n, 1);
    chk("t1_data_held", data1o, 32'hDEADBEEF);
    chk("t1_key_held", key1o, 2'b01);

    // five back-to-back requests, latency 1
    opcyc1.delete(); n_op = op1_n;
    for (int i = 0; i < 5; i++) begin
      rand1(); v1 = 1'b1; k = 0;
      do begin tick(); k++; end while (!s_acc1 && k < 50);
      chk("t2_accept_timeout", (k < 50) ? 1'b1 : 1'b0, 1'b1);
    end
    v1 = 1'b0;
    wait_idle();
    chk("t2_op_count", op1_n, n_op + 5);
    for (int i = 1; i < 5 && i < opcyc1.size(); i++)
      chk("t2_spacing", opcyc1[i] - opcyc1[i-1], 2);

    // eight back-to-back requests, latency 3: FIFO fills, held request waits
    opcyc3.delete(); n_op = op3_n; chk_rdy3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand3(); v3 = 1'b1; k = 0;
      do begin tick(); k++; end while (!s_acc3 && k < 50);
      chk("t2b_accept_timeout", (k < 50) ? 1'b1 : 1'b0, 1'b1);
    end
    v3 = 1'b0;
    wait_idle();
    chk_rdy3 = 1'b0;
    chk("t2b_saw_full", saw_full3, 1'b1);
    chk("t2b_op_count", op3_n, n_op + 8);
    for (int i = 1; i < 8 && i < opcyc3.size(); i++)
      chk("t2b_spacing", opcyc3[i] - opcyc3[i-1], 4);

    // single read, latency 3: address held from strobe through issue
    rand3(); op3i = 2'b01; v3 = 1'b1; t = cyc; n_rd = rd3_n;
    tick(); v3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cyc - 1 >= t + 2 && cyc - 1 <= t + 5) chk("t3_adr_stable", s_adr3, adr3i);
    end
    wait_idle();
    chk("t3_rd_cycle", rd3_cyc, t + 2);
    chk("t3_op_cycle", op3_cyc, t + 5);
    chk("t3_rd_count", rd3_n, n_rd + 1);

    // nop transfer: accepted, nothing happens
    op1i = 2'b00; v1 = 1'b1; n_rd = rd1_n; n_op = op1_n;
    tick(); v1 = 1'b0;
    chk("t4_nop_accepted", s_acc1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_busy", s_busy1, 1'b0);
    end
    chk("t4_no_rd", rd1_n, n_rd);
    chk("t4_no_op", op1_n, n_op);

    // reset during READ with two entries queued (latency 3)
    n_op = op3_n;
    for (int i = 0; i < 3; i++) begin
      rand3(); v3 = 1'b1; tick();
      chk("t5_accept", s_acc3, 1'b1);
    end
    v3 = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_rst_ready", s_rdy3, 1'b0);
    chk("t5_rst_op", s_op3, 2'b00);
    tick();
    chk("t5_busy_after", s_busy3, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    chk("t5_no_op", op3_n, n_op);
    chk("t5_idle", s_busy3, 1'b0);

    // clk_en dropped for three cycles during READ (latency 1)
    rand1(); v1 = 1'b1; t = cyc; tick(); v1 = 1'b0;
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_ready_frozen", s_rdy1, 1'b0);
      chk("t6_rd_frozen", s_rd1, 1'b0);
      chk("t6_op_frozen", s_op1, 2'b00);
    end
    clk_en = 1'b1;
    wait_idle();
    chk("t6_rd_cycle", rd1_cyc, t + 5);
    chk("t6_op_cycle", op1_cyc, t + 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
